// File: rtl/operand_entry_fsm.sv
// operand_entry_fsm: collects two 4-bit operands and a 3-bit opcode from
// switches, one value per press of a debounced enter key, and presents them
// to a downstream ALU. A debounced clear key restarts entry from scratch.
// Opcode 3'b111 is rejected and flagged on LED_op_err.
module operand_entry_fsm #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] SW,
    input  logic       SW_Cin,
    input  logic       KEY_enter_n,
    input  logic       KEY_clr_n,
    output logic [3:0] A_in,
    output logic [3:0] B_in,
    output logic [2:0] OP_sel,
    output logic       Cin,
    output logic       exec_pulse,
    output logic       result_valid,
    output logic [1:0] LED_state,
    output logic       LED_op_err
);

    // Debounce counter runs 0 .. DEBOUNCE_CYCLES-1.
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Key index 0 is enter, key index 1 is clear.
    localparam int K_ENTER = 0;
    localparam int K_CLR   = 1;

    typedef enum logic [1:0] {
        ST_A    = 2'b00,
        ST_B    = 2'b01,
        ST_OP   = 2'b10,
        ST_SHOW = 2'b11
    } state_t;

    logic [1:0]       w_key_raw;
    logic [1:0]       r_sync0;
    logic [1:0]       r_sync1;
    logic [1:0]       r_vld;
    logic [1:0]       r_level;
    logic [CNT_W-1:0] r_cnt [2];
    logic [1:0]       r_armed;
    logic [1:0]       r_press;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_a, w_a_nxt;
    logic [3:0] r_b, w_b_nxt;
    logic [2:0] r_op, w_op_nxt;
    logic       r_cin, w_cin_nxt;
    logic       r_err, w_err_nxt;
    logic       r_exec, w_exec_nxt;

    logic w_enter;
    logic w_clr;

    assign w_key_raw = {KEY_clr_n, KEY_enter_n};

    // Two-flop synchronizer for both keys; r_vld marks when the flops hold
    // real samples again after reset rather than their reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync0 <= 2'b11;
            r_sync1 <= 2'b11;
            r_vld   <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make r_sync1 take the old r_sync0,
            // giving two real flop stages; blocking here would collapse them.
            r_sync0 <= w_key_raw;
            r_sync1 <= r_sync0;
            r_vld   <= {r_vld[0], 1'b1};
        end
    end

    // Per-key debounce: accept a new level after DEBOUNCE_CYCLES consecutive
    // differing samples, and emit one press pulse on an accepted 1->0 change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 2'b11;
            r_armed <= 2'b00;
            r_press <= 2'b00;
            for (int k = 0; k < 2; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                r_press[k] <= 1'b0;
                if (r_sync1[k] == r_level[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    r_level[k] <= r_sync1[k];
                    r_cnt[k]   <= '0;
                    r_press[k] <= r_level[k] & r_armed[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
                // NOTE: a key only becomes able to press once it has been seen
                // released after reset, so a key held through reset is ignored
                // until it is let go and pressed again.
                if (r_vld[1] && r_sync1[k]) begin
                    r_armed[k] <= 1'b1;
                end
            end
        end
    end

    assign w_enter = r_press[K_ENTER];
    assign w_clr   = r_press[K_CLR];

    // State and operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cin   <= 1'b0;
            r_err   <= 1'b0;
            r_exec  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_op    <= w_op_nxt;
            r_cin   <= w_cin_nxt;
            r_err   <= w_err_nxt;
            r_exec  <= w_exec_nxt;
        end
    end

    // Next-state and capture logic; clear outranks enter.
    always_comb begin
        // NOTE: every output of this block gets a hold value first, so paths
        // that do not assign it cannot infer a latch.
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_cin_nxt   = r_cin;
        w_err_nxt   = r_err;
        w_exec_nxt  = 1'b0;

        if (w_clr) begin
            w_state_nxt = ST_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_op_nxt    = '0;
            w_cin_nxt   = 1'b0;
            w_err_nxt   = 1'b0;
        end else if (w_enter) begin
            unique case (r_state)
                ST_A: begin
                    w_a_nxt     = SW;
                    w_state_nxt = ST_B;
                end
                ST_B: begin
                    w_b_nxt     = SW;
                    w_state_nxt = ST_OP;
                end
                ST_OP: begin
                    if (SW[2:0] != 3'b111) begin
                        w_op_nxt    = SW[2:0];
                        w_cin_nxt   = SW_Cin;
                        w_err_nxt   = 1'b0;
                        w_exec_nxt  = 1'b1;
                        w_state_nxt = ST_SHOW;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
                ST_SHOW: begin
                    w_state_nxt = ST_A;
                end
                default: begin
                    w_state_nxt = ST_A;
                end
            endcase
        end
    end

    assign A_in         = r_a;
    assign B_in         = r_b;
    assign OP_sel       = r_op;
    assign Cin          = r_cin;
    assign exec_pulse   = r_exec;
    assign result_valid = (r_state == ST_SHOW);
    assign LED_state    = r_state;
    assign LED_op_err   = r_err;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Testbench for operand_entry_fsm with a short debounce window. A
// transaction-level model tracks which entry step the user is on and what
// values should be latched; each press is checked against it.
module tb_operand_entry_fsm;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] SW;
    logic       SW_Cin;
    logic       KEY_enter_n;
    logic       KEY_clr_n;
    logic [3:0] A_in;
    logic [3:0] B_in;
    logic [2:0] OP_sel;
    logic       Cin;
    logic       exec_pulse;
    logic       result_valid;
    logic [1:0] LED_state;
    logic       LED_op_err;

    int checks = 0;
    int errors = 0;

    // Monitor counters.
    int         n_changes  = 0;
    int         n_exec     = 0;
    int         n_exec_bad = 0;
    logic [1:0] prev_state = 2'b00;

    // Model: entry step 0=A,1=B,2=OP,3=SHOW and the values the user latched.
    int         m_state;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [2:0] m_op;
    logic       m_cin;
    logic       m_err;

    logic [15:0] dut_vec;
    assign dut_vec = {LED_state, A_in, B_in, OP_sel, Cin, LED_op_err, result_valid};

    operand_entry_fsm #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk          (clk),
        .rst          (rst),
        .SW           (SW),
        .SW_Cin       (SW_Cin),
        .KEY_enter_n  (KEY_enter_n),
        .KEY_clr_n    (KEY_clr_n),
        .A_in         (A_in),
        .B_in         (B_in),
        .OP_sel       (OP_sel),
        .Cin          (Cin),
        .exec_pulse   (exec_pulse),
        .result_valid (result_valid),
        .LED_state    (LED_state),
        .LED_op_err   (LED_op_err)
    );

    always #5 clk = ~clk;

    // Count state changes and exec strobes; exec must coincide exactly with
    // the first cycle spent in SHOW after leaving OP.
    always @(negedge clk) begin
        if (LED_state !== prev_state) n_changes++;
        if (exec_pulse === 1'b1) n_exec++;
        if (exec_pulse !== (LED_state == 2'b11 && prev_state == 2'b10)) n_exec_bad++;
        prev_state = LED_state;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_vec();
        logic [1:0] st;
        st = m_state[1:0];
        return {st, m_a, m_b, m_op, m_cin, m_err, (m_state == 3)};
    endfunction

    function automatic void model_clear();
        m_state = 0;
        m_a     = '0;
        m_b     = '0;
        m_op    = '0;
        m_cin   = 1'b0;
        m_err   = 1'b0;
    endfunction

    // Returns 1 when the enter press should fire an exec strobe.
    function automatic bit model_enter(input logic [3:0] sw, input logic cin);
        bit fire;
        fire = 1'b0;
        case (m_state)
            0: begin m_a = sw; m_state = 1; end
            1: begin m_b = sw; m_state = 2; end
            2: begin
                if (sw[2:0] != 3'b111) begin
                    m_op = sw[2:0]; m_cin = cin; m_err = 1'b0; m_state = 3; fire = 1'b1;
                end else begin
                    m_err = 1'b1;
                end
            end
            default: m_state = 0;
        endcase
        return fire;
    endfunction

    // Hold the selected keys low for 'hold' clocks, then release and let the
    // release debounce out.
    task automatic press(input bit en, input bit clr, input int hold);
        @(negedge clk);
        if (en)  KEY_enter_n = 1'b0;
        if (clr) KEY_clr_n   = 1'b0;
        repeat (hold) @(negedge clk);
        KEY_enter_n = 1'b1;
        KEY_clr_n   = 1'b1;
        repeat (DEB + 8) @(negedge clk);
    endtask

    task automatic enter_with(input logic [3:0] sw, input logic cin);
        bit unused;
        SW     = sw;
        SW_Cin = cin;
        press(1'b1, 1'b0, 10);
        unused = model_enter(sw, cin);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec, exp_vec());
        end
        checks++;
        if (exec_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_exec: got %b expected 0", exec_pulse);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_full_entry();
        int e0, c0, b0;
        e0 = n_exec; c0 = n_changes; b0 = n_exec_bad;
        enter_with(4'd5, 1'b0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL full_entry_a: got %h expected %h", dut_vec, exp_vec());
        end
        enter_with(4'd3, 1'b0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL full_entry_b: got %h expected %h", dut_vec, exp_vec());
        end
        enter_with(4'b0000, 1'b1);
        checks++;
        if (dut_vec !== 16'b11_0101_0011_000_1_0_1) begin
            errors++;
            $display("FAIL full_entry_op: got %h expected %h", dut_vec, 16'b11_0101_0011_000_1_0_1);
        end
        checks++;
        if (n_exec - e0 !== 1 || n_exec_bad != b0) begin
            errors++;
            $display("FAIL full_entry_exec: got %0d strobes (%0d misplaced) expected 1 (0)", n_exec - e0, n_exec_bad - b0);
        end
        checks++;
        if (n_changes - c0 !== 3) begin
            errors++;
            $display("FAIL full_entry_steps: got %0d expected 3", n_changes - c0);
        end
    endtask

    task automatic test_bounce();
        int c0;
        bit unused;
        c0 = n_changes;
        SW = 4'hA;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            KEY_enter_n = 1'b0;
            repeat (3) @(negedge clk);
            KEY_enter_n = 1'b1;
            @(negedge clk);
        end
        KEY_enter_n = 1'b0;
        repeat (10) @(negedge clk);
        KEY_enter_n = 1'b1;
        repeat (DEB + 8) @(negedge clk);
        unused = model_enter(SW, SW_Cin);
        checks++;
        if (n_changes - c0 !== 1) begin
            errors++;
            $display("FAIL bounce_advances: got %0d expected 1", n_changes - c0);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL bounce_outputs: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_bad_opcode();
        int e0;
        enter_with(4'h2, 1'b0);
        enter_with(4'h7, 1'b0);
        e0 = n_exec;
        enter_with(4'b1111, 1'b1);
        checks++;
        if (dut_vec !== exp_vec() || LED_state !== 2'b10 || LED_op_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_opcode_reject: got %h expected %h", dut_vec, exp_vec());
        end
        enter_with(4'b0101, 1'b0);
        checks++;
        if (dut_vec !== exp_vec() || OP_sel !== 3'd5 || LED_op_err !== 1'b0) begin
            errors++;
            $display("FAIL bad_opcode_recover: got %h expected %h", dut_vec, exp_vec());
        end
        checks++;
        if (n_exec - e0 !== 1) begin
            errors++;
            $display("FAIL bad_opcode_exec: got %0d expected 1", n_exec - e0);
        end
    endtask

    task automatic test_simultaneous();
        int e0;
        enter_with(4'h1, 1'b0);
        enter_with(4'hC, 1'b0);
        enter_with(4'h6, 1'b1);
        checks++;
        if (LED_state !== 2'b10) begin
            errors++;
            $display("FAIL simul_setup: got %b expected 10", LED_state);
        end
        e0 = n_exec;
        SW = 4'b0011;
        SW_Cin = 1'b1;
        press(1'b1, 1'b1, 10);
        model_clear();
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL simul_clear_wins: got %h expected %h", dut_vec, exp_vec());
        end
        checks++;
        if (n_exec - e0 !== 0) begin
            errors++;
            $display("FAIL simul_exec: got %0d expected 0", n_exec - e0);
        end
    endtask

    task automatic test_reset_mid_entry();
        enter_with(4'd9, 1'b0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL midrst_load: got %h expected %h", dut_vec, exp_vec());
        end
        SW = 4'd4;
        @(negedge clk);
        KEY_enter_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (dut_vec !== exp_vec() || exec_pulse !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got %h expected %h", dut_vec, exp_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        KEY_enter_n = 1'b1;
        repeat (DEB + 8) @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL midrst_no_advance: got %h expected %h", dut_vec, exp_vec());
        end
        enter_with(4'd6, 1'b0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL midrst_repress: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_hold();
        logic [15:0] held;
        enter_with(4'hE, 1'b0);
        enter_with(4'b1010, 1'b1);
        checks++;
        if (dut_vec !== exp_vec() || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_setup: got %h expected %h", dut_vec, exp_vec());
        end
        held = exp_vec();
        for (int i = 0; i < 100; i++) begin
            SW     = 4'($urandom);
            SW_Cin = 1'($urandom);
            @(negedge clk);
            checks++;
            if (dut_vec !== held) begin
                errors++;
                $display("FAIL hold_cycle%0d: got %h expected %h", i, dut_vec, held);
            end
        end
    endtask

    task automatic test_random();
        int          e0, c0, old_state, hold, exp_exec;
        logic [3:0]  sw_v;
        logic        cin_v;
        bit          do_clr;
        for (int it = 0; it < 40; it++) begin
            do_clr = ($urandom_range(0, 9) == 0);
            sw_v   = 4'($urandom);
            cin_v  = 1'($urandom);
            if (m_state == 2 && $urandom_range(0, 3) == 0) sw_v[2:0] = 3'b111;
            hold   = $urandom_range(8, 14);
            SW     = sw_v;
            SW_Cin = cin_v;
            e0 = n_exec; c0 = n_changes; old_state = m_state;
            press(!do_clr, do_clr, hold);
            exp_exec = 0;
            if (do_clr) model_clear();
            else exp_exec = model_enter(sw_v, cin_v) ? 1 : 0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rand%0d_outputs: got %h expected %h", it, dut_vec, exp_vec());
            end
            checks++;
            if (n_exec - e0 !== exp_exec) begin
                errors++;
                $display("FAIL rand%0d_exec: got %0d expected %0d", it, n_exec - e0, exp_exec);
            end
            checks++;
            if (n_changes - c0 !== ((old_state != m_state) ? 1 : 0)) begin
                errors++;
                $display("FAIL rand%0d_steps: got %0d expected %0d", it, n_changes - c0,
                         (old_state != m_state) ? 1 : 0);
            end
        end
    endtask

    task automatic test_exec_timing();
        checks++;
        if (n_exec_bad !== 0) begin
            errors++;
            $display("FAIL exec_timing: got %0d misplaced strobes expected 0", n_exec_bad);
        end
    endtask

    initial begin
        rst         = 1'b1;
        SW          = 4'h0;
        SW_Cin      = 1'b0;
        KEY_enter_n = 1'b1;
        KEY_clr_n   = 1'b1;
        test_reset();
        test_full_entry();
        test_bounce();
        test_bad_opcode();
        test_simultaneous();
        test_reset_mid_entry();
        test_hold();
        test_random();
        test_exec_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_entry_fsm.md
OPERAND_ENTRY_FSM -- requirements
Module: operand_entry_fsm

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz), giving the number of consecutive stable clocks required before a key level is accepted; legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port SW, input, 4, the raw operand/opcode switches; bits [2:0] carry the opcode in OP state.
REQ-005 SHALL have port SW_Cin, input, 1, the raw carry/borrow-in switch, sampled in OP state.
REQ-006 SHALL have port KEY_enter_n, input, 1, the raw active-low enter pushbutton.
REQ-007 SHALL have port KEY_clr_n, input, 1, the raw active-low clear pushbutton.
REQ-008 SHALL have ports A_in, B_in (output, 4 each), OP_sel (output, 3) and Cin (output, 1): registered operands driving the ALU directly.
REQ-009 SHALL have port exec_pulse, output, 1: one-cycle strobe marking new operands presented to the ALU.
REQ-010 SHALL have port result_valid, output, 1: high while in SHOW state.
REQ-011 SHALL have port LED_state, output, 2: current state code (A=00, B=01, OP=10, SHOW=11).
REQ-012 SHALL have port LED_op_err, output, 1: opcode-rejected flag.

Function
REQ-013 SHALL pass each raw key through a 2-flop synchronizer before debouncing.
REQ-014 SHALL, per key, hold a debounced level that changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive clocks; any bounce back SHALL restart the count at zero.
REQ-015 SHALL generate a registered one-cycle press pulse per key on the debounced 1->0 transition; release SHALL generate nothing; a held key SHALL produce exactly one pulse.
REQ-016 SHALL implement the FSM A -> B -> OP -> SHOW -> A, advancing only on an enter pulse.
REQ-017 On enter pulse in A, SHALL load A_in <= SW (SW sampled directly, no debounce) and go to B.
REQ-018 On enter pulse in B, SHALL load B_in <= SW and go to OP.
REQ-019 On enter pulse in OP with SW[2:0] != 3'b111, SHALL load OP_sel <= SW[2:0] and Cin <= SW_Cin, clear LED_op_err, go to SHOW and assert exec_pulse in the next cycle only.
REQ-020 On enter pulse in OP with SW[2:0] = 3'b111, SHALL stay in OP, leave OP_sel and Cin unchanged and set LED_op_err; the flag SHALL persist until the next accepted opcode, clear pulse or reset.
REQ-021 On enter pulse in SHOW, SHALL go to A keeping all operand outputs unchanged, so the ALU result stays on the display until overwritten.
REQ-022 On clear pulse in any state, SHALL go to A and zero A_in, B_in, OP_sel, Cin and LED_op_err.
REQ-023 SHALL give a clear pulse priority over a simultaneous enter pulse; the enter pulse is discarded.
REQ-024 SHALL hold all operand outputs stable except on the capture edges defined above.
REQ-025 Latency: an enter pulse high in cycle n SHALL update the registers and state at the edge ending cycle n; exec_pulse SHALL be high in cycle n+1.

Reset
REQ-026 rst high SHALL asynchronously force state A, A_in=0, B_in=0, OP_sel=0, Cin=0, exec_pulse=0, result_valid=0, LED_op_err=0, LED_state=00, debounced levels=1 (released), debounce counters=0, synchronizer flops=1.
REQ-027 Reset asserted mid-entry or mid-debounce SHALL discard the partial entry; no press pulse SHALL be produced by a key held through reset deassertion.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Full entry: SW=5 enter, SW=3 enter, SW=000/Cin=1 enter -> A_in=5, B_in=3, OP_sel=0, Cin=1, one exec_pulse, result_valid=1, LED_state=11.
REQ-029 Bounce: KEY_enter_n toggles low 3 clk/high 1 clk twice, then low 10 clk -> exactly one press pulse, one state advance.
REQ-030 Bad opcode: in OP, SW=111 enter -> state stays 10, LED_op_err=1; then SW=101 enter -> OP_sel=5, LED_op_err=0, SHOW.
REQ-031 Simultaneous: in OP, both keys' pulses in the same cycle -> state A, all operands 0, no exec_pulse.
REQ-032 Reset mid-entry: after A=9 loaded, assert rst 1 clk while enter held -> all outputs at reset values, no advance after release and re-press only.
REQ-033 Hold: in SHOW, change SW freely for 100 clk -> A_in, B_in, OP_sel, Cin unchanged.
